// File: rtl/game_sched_pkg.sv
// Shared types and defaults for the game tick scheduler.
package game_sched_pkg;

    localparam int DEF_NUM_UNITS = 4;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int FRAME_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT
    } sched_state_e;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; the reset value of the sample register
// decides whether a level that is already high at reset release counts as an edge.
module edge_rise #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Previous-cycle sample of d.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) d_q <= RST_VAL;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Per-tick sequencer: on each game tick, issues one-hot update requests to
// the enabled units in ascending order, waits for each done (or a timeout),
// then pulses frame_done and counts the frame.
module game_tick_scheduler
    import game_sched_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_clk,
    input  logic                   pause,
    input  logic [NUM_UNITS-1:0]   unit_en,
    input  logic [NUM_UNITS-1:0]   done,
    input  logic                   err_clr,
    output logic [NUM_UNITS-1:0]   req,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_e         state, state_d;
    logic [NUM_UNITS-1:0] mask;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     nxt_idx;
    logic                 nxt_found;
    logic [TW-1:0]        tcnt;
    logic                 tick;
    logic                 start;
    logic                 done_hit;
    logic                 to_hit;
    logic                 unit_end;

    // Sample register starts high so a game_clk already high at reset release
    // is not mistaken for a tick.
    edge_rise #(.RST_VAL(1'b1)) u_tick_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (game_clk),
        .rise (tick)
    );

    // Lowest enabled unit at frame start, and next enabled unit above idx.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        first_idx = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (unit_en[i]) first_idx = IDX_W'(i);
            if (mask[i] && (IDX_W'(i) > idx)) begin
                nxt_idx   = IDX_W'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // Next-state logic; done takes priority over a coincident timeout.
    always_comb begin
        state_d  = state;
        start    = 1'b0;
        done_hit = done[idx];
        to_hit   = (tcnt == TW'(TIMEOUT - 1)) && !done_hit;
        unit_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick && !pause) begin
                    start   = 1'b1;
                    state_d = (|unit_en) ? ST_ISSUE : ST_COMMIT;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_hit || to_hit) begin
                    unit_end = 1'b1;
                    state_d  = nxt_found ? ST_ISSUE : ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Frame datapath: mask/index, timeout counter, frame counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= '0;
            idx         <= '0;
            tcnt        <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done <= (state == ST_COMMIT);
            if (state == ST_COMMIT) frame_cnt <= frame_cnt + 1'b1;

            if (start) begin
                mask <= unit_en;
                idx  <= first_idx;
            end else if (unit_end && nxt_found) begin
                idx <= nxt_idx;
            end

            tcnt <= (state == ST_WAIT) ? tcnt + 1'b1 : '0;

            // Set events outrank a same-cycle clear.
            if (tick && state != ST_IDLE) overrun <= 1'b1;
            else if (err_clr)             overrun <= 1'b0;

            if (state == ST_WAIT && to_hit) timeout_err <= 1'b1;
            else if (err_clr)               timeout_err <= 1'b0;
        end
    end

    // One-hot request to the active unit while it is being serviced.
    always_comb begin
        req = '0;
        if (state == ST_ISSUE || state == ST_WAIT) req[idx] = 1'b1;
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: stimulus pushes the expected
// request sequence and frame-count values; a monitor pops them as the DUT
// raises a new req or pulses frame_done.
module tb_game_tick_scheduler;

    localparam int NU = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          game_clk;
    logic          pause;
    logic [NU-1:0] unit_en;
    logic [NU-1:0] done;
    logic          err_clr;
    logic [NU-1:0] req;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic          overrun;
    logic          timeout_err;

    typedef struct {
        logic        is_fd;
        logic [15:0] val;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [NU-1:0] stuck_mask = '0;
    int            req1_cycles = 0;

    game_tick_scheduler #(.NUM_UNITS(NU), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .game_clk    (game_clk),
        .pause       (pause),
        .unit_en     (unit_en),
        .done        (done),
        .err_clr     (err_clr),
        .req         (req),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [NU-1:0] r);
        exp_t e;
        e.is_fd = 1'b0;
        e.val   = 16'(r);
        sb.push_back(e);
    endtask

    task automatic push_fd(input logic [15:0] c);
        exp_t e;
        e.is_fd = 1'b1;
        e.val   = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk) game_clk = 1'b1;
        repeat (2) @(negedge clk);
        game_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (!busy && !frame_done && sb.size() == 0) break;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: frame not finished after %0d cycles, %0d events pending",
                     name, budget, sb.size());
        end
    endtask

    // Monitor: compares every new request and every frame_done against the scoreboard.
    initial begin
        logic [NU-1:0] prev_req;
        exp_t          e;
        prev_req = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = '0;
            end else begin
                if (req == 4'b0010) req1_cycles++;
                if (!$onehot0(req)) begin
                    errors++;
                    $display("FAIL req_onehot: got %b required at most one bit", req);
                end
                if (req != '0 && req != prev_req) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL req_unexpected: got %b required no request", req);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_fd || 16'(req) != e.val) begin
                            errors++;
                            $display("FAIL req_seq: got req %b required %s 0x%0h",
                                     req, e.is_fd ? "frame_done cnt" : "req", e.val);
                        end
                    end
                end
                if (frame_done) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL fd_unexpected: got frame_done cnt 0x%0h required none", frame_cnt);
                    end else begin
                        e = sb.pop_front();
                        if (!e.is_fd || frame_cnt != e.val) begin
                            errors++;
                            $display("FAIL fd_seq: got frame_done cnt 0x%0h required %s 0x%0h",
                                     frame_cnt, e.is_fd ? "frame_done cnt" : "req", e.val);
                        end
                    end
                end
                prev_req = req;
            end
        end
    end

    // Unit model: each unit returns a one-cycle done 3 cycles after its req rises.
    initial begin
        int            cnt[NU];
        logic [NU-1:0] rprev;
        logic [NU-1:0] nd;
        for (int i = 0; i < NU; i++) cnt[i] = 0;
        rprev = '0;
        done  = '0;
        forever begin
            @(negedge clk);
            nd = '0;
            for (int i = 0; i < NU; i++) begin
                if (rst) begin
                    cnt[i] = 0;
                end else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) nd[i] = 1'b1;
                    end
                    if (req[i] && !rprev[i] && !stuck_mask[i]) cnt[i] = 3;
                end
            end
            done  = nd;
            rprev = rst ? '0 : req;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        game_clk = 1'b1;
        pause    = 1'b0;
        unit_en  = '0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);

        // game_clk high across reset release must not start a frame.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("high_at_release_busy", 32'(busy), 32'h0);
        game_clk = 1'b0;
        @(negedge clk);

        // All four units, ascending order.
        unit_en = 4'b1111;
        push_req(4'b0001); push_req(4'b0010); push_req(4'b0100); push_req(4'b1000);
        push_fd(16'd1);
        @(negedge clk) game_clk = 1'b1;
        @(negedge clk);
        check("busy_after_edge", 32'(busy), 32'h1);
        check("req_after_edge", 32'(req), 32'h1);
        @(negedge clk) game_clk = 1'b0;
        wait_idle("frame_all", 200);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // Sparse mask; mid-frame unit_en/pause changes must not matter.
        unit_en = 4'b0101;
        push_req(4'b0001); push_req(4'b0100); push_fd(16'd2);
        tick();
        unit_en = 4'b1111;
        pause   = 1'b1;
        wait_idle("frame_sparse", 200);
        pause = 1'b0;

        // Empty mask: frame_done two cycles after the edge, no request.
        unit_en = 4'b0000;
        push_fd(16'd3);
        @(negedge clk) game_clk = 1'b1;
        @(negedge clk);
        check("empty_fd_early", 32'(frame_done), 32'h0);
        @(negedge clk);
        check("empty_fd_pulse", 32'(frame_done), 32'h1);
        check("empty_req", 32'(req), 32'h0);
        game_clk = 1'b0;
        wait_idle("frame_empty", 50);

        // Unit 1 never answers: one ISSUE cycle plus TIMEOUT wait cycles.
        unit_en     = 4'b0111;
        stuck_mask  = 4'b0010;
        req1_cycles = 0;
        push_req(4'b0001); push_req(4'b0010); push_req(4'b0100); push_fd(16'd4);
        tick();
        wait_idle("frame_timeout", 200);
        check("req1_cycles", 32'(req1_cycles), 32'd17);
        check("timeout_err_set", 32'(timeout_err), 32'h1);
        check("overrun_clean", 32'(overrun), 32'h0);
        stuck_mask = '0;
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("timeout_err_clr", 32'(timeout_err), 32'h0);

        // Second edge while busy, with err_clr in the same cycle: overrun wins.
        unit_en = 4'b1111;
        push_req(4'b0001); push_req(4'b0010); push_req(4'b0100); push_req(4'b1000);
        push_fd(16'd5);
        tick();
        @(negedge clk) begin
            game_clk = 1'b1;
            err_clr  = 1'b1;
        end
        @(negedge clk) begin
            err_clr  = 1'b0;
            game_clk = 1'b0;
        end
        check("overrun_set", 32'(overrun), 32'h1);
        wait_idle("frame_overrun", 200);
        check("overrun_cnt_once", 32'(frame_cnt), 32'd5);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("overrun_clr", 32'(overrun), 32'h0);

        // Paused tick in IDLE is ignored.
        pause = 1'b1;
        tick();
        repeat (4) @(negedge clk);
        check("pause_busy", 32'(busy), 32'h0);
        check("pause_cnt", 32'(frame_cnt), 32'd5);
        check("pause_overrun", 32'(overrun), 32'h0);
        pause = 1'b0;

        // Counter wrap: preload near the top, then two empty frames.
        @(negedge clk) force dut.frame_cnt = 16'hFFFE;
        @(negedge clk) release dut.frame_cnt;
        unit_en = 4'b0000;
        push_fd(16'hFFFF);
        tick();
        wait_idle("frame_pre_wrap", 50);
        push_fd(16'h0000);
        tick();
        wait_idle("frame_wrap", 50);
        check("wrap_cnt", 32'(frame_cnt), 32'h0);

        // Reset while waiting on unit 0.
        unit_en    = 4'b1111;
        stuck_mask = 4'b1111;
        push_req(4'b0001);
        tick();
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(req), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_frame_done", 32'(frame_done), 32'h0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("mid_rst_flags", 32'({overrun, timeout_err}), 32'h0);
        rst        = 1'b0;
        stuck_mask = '0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
